masked_sbox_word_collector: RTL

//  Sits directly downstream of the 2-share masked S-box output affine stage.

---
 rtl/masked_sbox_word_collector.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/masked_sbox_word_collector.sv
// ----------------------------------------------------------------------------
// masked_sbox_word_collector
//
// Purpose
//    Collects 2-share masked S-box output bytes into 2-share words of NBYTES
//    bytes. It sits directly after the masked S-box output affine stage.
//    Byte 0 lands in bits [7:0], so the word is packed LSB first.
//    The two shares have separate datapaths and separate flops. No logic cone
//    ever combines share 0 with share 1.
//    The output register doubles as a one-word skid buffer. A final byte that
//    arrives while the output is blocked is parked in the fill buffer, and the
//    input stalls until the output frees up.
//
// Optional feature
//    COLLECTOR_REFRESH_EN : adds port rnd. On every load of the output
//    registers, both shares are XORed with the rnd value sampled in that
//    cycle. The unmasked value (share0 ^ share1) does not change.
//    Latency and handshaking are the same with and without this macro.
//
// Parameters
//    NBYTES : bytes per output word
//    CNT_W  : fill counter width, must satisfy 2**CNT_W >= NBYTES
//
// Ports
//    clk         in   rising-edge clock
//    rst_n       in   asynchronous active-low reset
//    in_valid    in   input byte valid
//    in_ready    out  collector can accept a byte (!fill_full && !flush)
//    in_share0   in   share 0 of the S-box output byte
//    in_share1   in   share 1 of the S-box output byte
//    flush       in   discard the partially or fully filled word
//    out_valid   out  shared word available
//    out_ready   in   consumer takes the word
//    out_share0  out  share 0 of the packed word
//    out_share1  out  share 1 of the packed word
//    fill_cnt    out  bytes held in the fill buffer (NBYTES mod 2**CNT_W when full)
//    rnd         in   refresh randomness (only with COLLECTOR_REFRESH_EN)
// ----------------------------------------------------------------------------
module masked_sbox_word_collector #(
   parameter int NBYTES = 4,
   parameter int CNT_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_share0,
   input  logic [7:0]            in_share1,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_share0,
   output logic [8*NBYTES-1:0]   out_share1,
`ifdef COLLECTOR_REFRESH_EN
   input  logic [8*NBYTES-1:0]   rnd,
`endif
   output logic [CNT_W-1:0]      fill_cnt
);

   localparam int W = 8 * NBYTES;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);
   // When the buffer is full, the count wraps. For example, 4 bytes in a
   // 2-bit counter reads back as 0.
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBYTES % (2 ** CNT_W));

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             fill_full_q, fill_full_d;
   logic [W-1:0]     fill0_q,     fill0_d;
   logic [W-1:0]     fill1_q,     fill1_d;
   logic [W-1:0]     out0_q,      out0_d;
   logic [W-1:0]     out1_q,      out1_d;
   logic             out_valid_q, out_valid_d;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   logic             accept;
   logic             last_byte;
   logic             slot_free;
   logic             drain;
   logic             direct_load;
   logic             held_load;
   logic             load;
   logic [NBYTES-1:0] wr_slot;
   logic [W-1:0]     refresh_mask;

   assign in_ready  = !fill_full_q && !flush;
   assign accept    = in_valid && in_ready;
   assign last_byte = (cnt_q == LAST_CNT);
   // The output slot can take a new word if it is empty, or if it is being
   // drained on this same edge. Loading while draining gives back-to-back
   // words with no bubble.
   assign slot_free = !out_valid_q || out_ready;
   assign drain     = out_valid_q && out_ready;

   // Final byte goes straight to the output: no extra cycle of latency.
   assign direct_load = accept && last_byte && slot_free;
   // A parked word moves out once the slot frees. A flush in the same cycle
   // takes priority and drops the parked word.
   assign held_load   = fill_full_q && slot_free && !flush;
   // accept needs !fill_full_q, so direct_load and held_load never overlap.
   assign load        = direct_load || held_load;

`ifdef COLLECTOR_REFRESH_EN
   assign refresh_mask = rnd;
`else
   assign refresh_mask = '0;
`endif

   // ------------------------------------------------------------------------
   // Fill buffer write: one byte lane per slot, one set of lanes per share.
   // fill*_d always holds the complete word as it is after this cycle's
   // write. On a final-byte accept, that value is exactly the word to load
   // into the output. While a word is parked, no write happens, so fill*_d
   // equals the parked word.
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_slot
         assign wr_slot[gi] = accept && (cnt_q == CNT_W'(gi));
         assign fill0_d[8*gi +: 8] = wr_slot[gi] ? in_share0 : fill0_q[8*gi +: 8];
         assign fill1_d[8*gi +: 8] = wr_slot[gi] ? in_share1 : fill1_q[8*gi +: 8];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Fill counter and full flag
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_d       = cnt_q;
      fill_full_d = fill_full_q;
      if (flush) begin
         cnt_d       = '0;
         fill_full_d = 1'b0;
      end else if (accept) begin
         if (last_byte) begin
            // The counter wraps straight away. While the word is parked,
            // fill_cnt reports the full value instead of the counter.
            cnt_d       = '0;
            fill_full_d = !slot_free;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (held_load) begin
         fill_full_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Output register. Each share has its own register. The refresh mask is
   // XORed into each share on its own, so no share0/share1 combination
   // exists anywhere.
   // ------------------------------------------------------------------------
   always_comb begin
      out0_d      = out0_q;
      out1_d      = out1_q;
      out_valid_d = out_valid_q;
      if (load) begin
         out0_d      = fill0_d ^ refresh_mask;
         out1_d      = fill1_d ^ refresh_mask;
         out_valid_d = 1'b1;
      end else if (drain) begin
         // Data registers keep their last value; only the valid flag drops.
         out_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         fill_full_q <= 1'b0;
         fill0_q     <= '0;
         fill1_q     <= '0;
         out0_q      <= '0;
         out1_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         fill_full_q <= fill_full_d;
         fill0_q     <= fill0_d;
         fill1_q     <= fill1_d;
         out0_q      <= out0_d;
         out1_q      <= out1_d;
         out_valid_q <= out_valid_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out_valid  = out_valid_q;
   assign out_share0 = out0_q;
   assign out_share1 = out1_q;
   assign fill_cnt   = fill_full_q ? FULL_CNT : cnt_q;

endmodule
